// File: rtl/death_count_display.sv
// rtl/death_count_display.sv - BCD digit pair to active-low HEX pair with blanking, error glyph and change blink
// Every change in the input count restarts a blank/show blink sequence that ends with the digits visible.
module death_count_display #(
  parameter int BLINK_HALF_PERIOD = 12500000,
  parameter int BLINK_TOGGLES     = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] tenths,
  input  logic [3:0] ones,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       flashing
);

  localparam int TW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam int CW = $clog2(BLINK_TOGGLES + 1);

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_ERR   = 7'h06;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_ON  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      t_q, t_d, o_q, o_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      hex1_q, hex1_d, hex0_q, hex0_d;
  logic            flashing_q, flashing_d;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = GLYPH_ERR;
    endcase
  endfunction

  always_comb begin
    t_d        = tenths;
    o_d        = ones;
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    hex1_d     = GLYPH_BLANK;
    hex0_d     = GLYPH_BLANK;
    flashing_d = (state_q != IDLE);

    if (state_q != IDLE) begin
      if (timer_q == '0) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(BLINK_TOGGLES)) begin
          state_d = IDLE;
        end else begin
          state_d = (state_q == BLINK_OFF) ? BLINK_ON : BLINK_OFF;
          timer_d = TW'(BLINK_HALF_PERIOD - 1);
        end
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end

    // A new count always wins, even over the final expiry of a running sequence.
    if ({tenths, ones} != {t_q, o_q}) begin
      state_d = BLINK_OFF;
      timer_d = TW'(BLINK_HALF_PERIOD - 1);
      cnt_d   = '0;
    end

    if (state_q != BLINK_OFF) begin
      if (t_q > 4'd9)       hex1_d = GLYPH_ERR;
      else if (t_q == 4'd0) hex1_d = GLYPH_BLANK;
      else                  hex1_d = glyph(t_q);
      hex0_d = glyph(o_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      o_q        <= '0;
      timer_q    <= '0;
      cnt_q      <= '0;
      hex1_q     <= GLYPH_BLANK;
      hex0_q     <= 7'h40;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      o_q        <= o_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
      flashing_q <= flashing_d;
    end
  end

  assign HEX1     = hex1_q;
  assign HEX0     = hex0_q;
  assign flashing = flashing_q;

endmodule

// File: tb/tb_death_count_display.sv
// tb/tb_death_count_display.sv - scoreboard bench for death_count_display with 4-cycle half-phases and 4 toggles
module tb_death_count_display;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] tenths, ones;
  logic [6:0] HEX1, HEX0;
  logic       flashing;

  typedef struct {
    logic [6:0] h1;
    logic [6:0] h0;
    logic       fl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  death_count_display #(
    .BLINK_HALF_PERIOD(4),
    .BLINK_TOGGLES(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .tenths(tenths),
    .ones(ones),
    .HEX1(HEX1),
    .HEX0(HEX0),
    .flashing(flashing)
  );

  always #5 Clk = ~Clk;

  task automatic push_n(input logic [6:0] h1, input logic [6:0] h0, input logic fl, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{h1, h0, fl});
  endtask

  // Expected view after edges k+1..k+20 when the count changes at edge k.
  task automatic push_blink(input logic [6:0] h1, input logic [6:0] h0);
    push_n(7'h7F, 7'h7F, 1'b1, 4);
    push_n(h1, h0, 1'b1, 4);
    push_n(7'h7F, 7'h7F, 1'b1, 4);
    push_n(h1, h0, 1'b1, 4);
    push_n(h1, h0, 1'b0, 4);
  endtask

  task automatic test_reset();
    Reset = 1'b1; tenths = 4'd0; ones = 4'd0;
    repeat (2) @(negedge Clk);
    total++;
    if ({HEX1, HEX0, flashing} !== {7'h7F, 7'h40, 1'b0}) begin
      bad++;
      $display("FAIL reset_held got=%h/%h/%b exp=7f/40/0", HEX1, HEX0, flashing);
    end
    Reset = 1'b0;
    push_n(7'h7F, 7'h40, 1'b0, 20);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if ({HEX1, HEX0, flashing} !== {e.h1, e.h0, e.fl}) begin
        bad++;
        $display("FAIL reset_stable cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i, HEX1, HEX0, flashing, e.h1, e.h0, e.fl);
      end
    end
  endtask

  task automatic test_change(input string name, input logic [3:0] t, input logic [3:0] o,
                             input logic [6:0] h1, input logic [6:0] h0);
    tenths = t; ones = o;
    push_blink(h1, h0);
    @(negedge Clk);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if ({HEX1, HEX0, flashing} !== {e.h1, e.h0, e.fl}) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h/%h/%b exp=%h/%h/%b", name, i + 1, HEX1, HEX0, flashing, e.h1, e.h0, e.fl);
      end
    end
  endtask

  task automatic test_restart();
    tenths = 4'd0; ones = 4'd3;
    push_n(7'h7F, 7'h7F, 1'b1, 4);
    push_n(7'h7F, 7'h30, 1'b1, 2);
    push_blink(7'h7F, 7'h19);
    @(negedge Clk);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if ({HEX1, HEX0, flashing} !== {e.h1, e.h0, e.fl}) begin
        bad++;
        $display("FAIL restart cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i + 1, HEX1, HEX0, flashing, e.h1, e.h0, e.fl);
      end
      if (i == 4) ones = 4'd4;
    end
  endtask

  task automatic test_final_expiry();
    tenths = 4'd0; ones = 4'd5;
    push_n(7'h7F, 7'h7F, 1'b1, 4);
    push_n(7'h7F, 7'h12, 1'b1, 4);
    push_n(7'h7F, 7'h7F, 1'b1, 4);
    push_n(7'h7F, 7'h12, 1'b1, 4);
    push_blink(7'h7F, 7'h02);
    @(negedge Clk);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if ({HEX1, HEX0, flashing} !== {e.h1, e.h0, e.fl}) begin
        bad++;
        $display("FAIL final_expiry cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i + 1, HEX1, HEX0, flashing, e.h1, e.h0, e.fl);
      end
      if (i == 14) ones = 4'd6;
    end
  endtask

  task automatic test_reset_mid();
    tenths = 4'd9; ones = 4'd9;
    push_n(7'h7F, 7'h7F, 1'b1, 2);
    push_n(7'h7F, 7'h40, 1'b0, 2);
    push_blink(7'h10, 7'h10);
    @(negedge Clk);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if ({HEX1, HEX0, flashing} !== {e.h1, e.h0, e.fl}) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i + 1, HEX1, HEX0, flashing, e.h1, e.h0, e.fl);
      end
      if (i == 1) Reset = 1'b1;
      if (i == 2) Reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_change("blink_0_to_3", 4'd0, 4'd3, 7'h7F, 7'h30);
    test_change("digits_42", 4'd4, 4'd2, 7'h19, 7'h24);
    test_change("digits_07", 4'd0, 4'd7, 7'h7F, 7'h78);
    test_restart();
    test_change("err_ones", 4'd0, 4'd12, 7'h7F, 7'h06);
    test_change("err_tenths", 4'd11, 4'd12, 7'h06, 7'h06);
    test_change("to_99", 4'd9, 4'd9, 7'h10, 7'h10);
    test_change("wrap_00", 4'd0, 4'd0, 7'h7F, 7'h40);
    test_final_expiry();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/death_count_display.md
Name: death_count_display

Overview:
- Downstream consumer of the death counter's BCD digit pair (tenths, ones); drives two board HEX seven-segment displays (active-low).
- Adds leading-zero blanking, an error glyph for non-BCD input, and a blink sequence on every count change so the player notices a death.
- Sits between the death counter and the top-level HEX pins.

Parameters:
- BLINK_HALF_PERIOD, 12500000, cycles per blink half-phase (0.25 s at 50 MHz); must be >= 1.
- BLINK_TOGGLES, 6, number of half-phases per blink sequence; must be even and >= 2, so the sequence ends visible.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- tenths  in  4  BCD tens digit from death counter.
- ones  in  4  BCD ones digit from death counter.
- HEX1  out  7  tens display, active-low, bit order {g,f,e,d,c,b,a}.
- HEX0  out  7  ones display, active-low, same order.
- flashing  out  1  high while a blink sequence is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - Capture regs t_q and o_q = 0; state = IDLE; timer = 0; toggle count = 0.
  - HEX0 = 7'h40 ("0"); HEX1 = 7'h7F (blank); flashing = 0.
- Capture and latency:
  - t_q and o_q register tenths and ones every cycle.
  - HEX0, HEX1 and flashing are registered from t_q, o_q and state.
  - Input change to HEX change is 2 cycles.
- Glyphs (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank=7F; error "E"=06.
- Digit values 10-15 show "E" on that digit. Error takes priority over leading-zero blanking.
- Leading zero: when t_q == 0, HEX1 is blank. HEX0 always shows its digit, so a count of 00 displays as blank + "0".
- Change detect: at any edge where {tenths, ones} != {t_q, o_q}, the block:
  - loads state = BLINK_OFF;
  - loads timer = BLINK_HALF_PERIOD-1;
  - loads toggle count = 0.
  - t_q and o_q update on the same edge.
- State machine (IDLE, BLINK_OFF, BLINK_ON):
  - IDLE: digits shown normally; flashing = 0.
  - BLINK_OFF: HEX0 = HEX1 = 7F.
  - BLINK_ON: digits shown normally.
  - flashing = 1 in both BLINK states.
  - While in a BLINK state, timer decrements each cycle.
  - At timer == 0, toggle count increments. If the new count == BLINK_TOGGLES, go to IDLE. Otherwise swap OFF/ON and reload timer = BLINK_HALF_PERIOD-1.
  - Total sequence length = BLINK_HALF_PERIOD*BLINK_TOGGLES cycles.
- Boundary conditions:
  - Change during a blink restarts the sequence from BLINK_OFF with a full timer. The new digits show once in an ON phase.
  - Change on the same edge as the final timer expiry: the restart wins; state goes to BLINK_OFF, not IDLE.
  - Wrap 99 -> 00 is a change; it blinks, and the final display is blank + "0".
  - Reset mid-blink aborts immediately to reset values on the next edge.
  - Reset has priority over change detection.
  - Input held constant: no blink; outputs stable.
- Width rules:
  - Timer width = clog2(BLINK_HALF_PERIOD) bits, minimum 1.
  - Toggle count width = clog2(BLINK_TOGGLES+1) bits.

Test Plan:
(Parameters for all scenarios: BLINK_HALF_PERIOD=4, BLINK_TOGGLES=4.)
- Reset held 2 cycles, inputs 0/0 -> HEX1=7F, HEX0=40, flashing=0, stable for 20 cycles.
- ones 0->3 at edge k -> flashing=1 and HEX0=HEX1=7F at k+1..k+4. HEX0=30, HEX1=7F at k+5..k+8. Blank at k+9..k+12. HEX0=30 with flashing=0 from k+17 onward.
- tenths=4, ones=2 settled (no blink pending) -> HEX1=19, HEX0=24. tenths=0, ones=7 -> final HEX1=7F, HEX0=78.
- Second change (3->4) 6 cycles into a blink -> sequence restarts: next 4 cycles blank, then HEX0=19, total 16 cycles of flashing after the restart.
- ones=12 (invalid), tenths=0 -> after blink, HEX0=06, HEX1=7F. tenths=11 -> HEX1=06.
- Reset asserted mid-BLINK_OFF with inputs 9/9 -> next edge HEX0=40, HEX1=7F, flashing=0. After release, 99 differs from 00 -> a new blink starts, ending at HEX1=10, HEX0=10.
